// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl: takes one load request from the pipeline and issues a word-aligned memory
// read. It then extracts the addressed byte or halfword from the big-endian read word and
// sign- or zero-extends it. Error responses are produced for an illegal size, for a memory
// timeout, and (optionally) for a misaligned access.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/req_ready        load request handshake; req_ready high only in IDLE
//   req_addr/size/unsigned     byte address, size (00 B, 01 H, 10 W, 11 illegal), zero-extend
//   mem_req/mem_addr           read strobe (held in WAIT_MEM) and word-aligned address
//   mem_ack/mem_rdata          read data return, byte offset 0 in bits [31:24]
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_err           extended result; rsp_data is 0 when rsp_err is set
//   stall                      high whenever the block is busy (state != IDLE)
//
// Configuration: define LOAD_EXT_MISALIGN_TRAP_EN to turn misaligned halfword/word loads into
// error responses. When it is undefined, the low address bits are ignored for those sizes.
module load_extend_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16  // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        stall
);

  typedef enum logic [1:0] {StIdle = 2'd0, StWaitMem = 2'd1, StResp = 2'd2} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        misalign;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  // Request-time error detection; errors skip the memory access entirely.
  always_comb begin
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = (req_size == 2'b11) || misalign;
  end

  // Lane selection and extension from the captured request; big-endian byte order.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[31:24];
      2'd1:    byte_sel = mem_rdata[23:16];
      2'd2:    byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'b00:   ext_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ext_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          size_d = req_size;
          uns_d  = req_unsigned;
          cnt_d  = 8'd0;
          data_d = 32'h0;
          err_d  = req_err;
          state_d = req_err ? StResp : StWaitMem;
        end
      end
      StWaitMem: begin
        // An ack in the expiry cycle still returns data.
        if (mem_ack) begin
          data_d  = ext_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          data_d  = 32'h0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      cnt_q   <= 8'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_req   = (state_q == StWaitMem);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign stall     = (state_q != StIdle);

endmodule

// File: tb/tb_load_extend_ctrl.sv
module tb_load_extend_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        stall;

  int total = 0;
  int bad   = 0;

  load_extend_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load with a single-cycle memory ack (if memory is requested) and returns
  // what was observed in the response cycle.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, output logic saw_req,
                          output logic valid, output logic [31:0] data, output logic err);
    req_valid = 1'b1; req_addr = addr; req_size = size; req_unsigned = uns;
    tick();
    req_valid = 1'b0;
    saw_req = mem_req;
    if (mem_req) begin
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
    end
    valid = rsp_valid; data = rsp_data; err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total += 7;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lb();
    req_valid = 1'b1; req_addr = 32'h103; req_size = 2'b00; req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    total += 4;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL lb_mem_req got=%b exp=1", mem_req); end
    if (mem_addr !== 32'h100) begin bad++; $display("FAIL lb_mem_addr got=%h exp=100", mem_addr); end
    if (stall !== 1'b1) begin bad++; $display("FAIL lb_stall got=%b exp=1", stall); end
    if (req_ready !== 1'b0) begin bad++; $display("FAIL lb_req_ready got=%b exp=0", req_ready); end
    mem_ack = 1'b1; mem_rdata = 32'h123456F0;
    tick();
    mem_ack = 1'b0;
    total += 4;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL lb_rsp_valid got=%b exp=1", rsp_valid); end
    if (rsp_data !== 32'hFFFFFFF0) begin bad++; $display("FAIL lb_data got=%h exp=fffffff0", rsp_data); end
    if (rsp_err !== 1'b0) begin bad++; $display("FAIL lb_err got=%b exp=0", rsp_err); end
    if (mem_req !== 1'b0) begin bad++; $display("FAIL lb_mem_req_drop got=%b exp=0", mem_req); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total += 1;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL lb_back_idle got=%b exp=1", req_ready); end
  endtask

  task automatic test_extend();
    logic [31:0] addr_t  [6] = '{32'h202, 32'h202, 32'h100, 32'h101, 32'h102, 32'h300};
    logic [1:0]  size_t  [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    logic        uns_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] rdata_t [6] = '{32'hAAAA8001, 32'hAAAA8001, 32'h80112233, 32'h80112233,
                                 32'h0000A500, 32'hDEADBEEF};
    logic [31:0] exp_t   [6] = '{32'h00008001, 32'hFFFF8001, 32'h00000080, 32'h00000011,
                                 32'hFFFFFFA5, 32'hDEADBEEF};
    logic saw, v, e;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      run_load(addr_t[i], size_t[i], uns_t[i], rdata_t[i], saw, v, d, e);
      total += 3;
      if (v !== 1'b1) begin bad++; $display("FAIL ext%0d_valid got=%b exp=1", i, v); end
      if (d !== exp_t[i]) begin bad++; $display("FAIL ext%0d_data got=%h exp=%h", i, d, exp_t[i]); end
      if (e !== 1'b0) begin bad++; $display("FAIL ext%0d_err got=%b exp=0", i, e); end
    end
  endtask

  task automatic test_errors();
    logic saw, v, e;
    logic [31:0] d;
    // Illegal size: error, no memory access.
    run_load(32'h400, 2'b11, 1'b0, 32'h12345678, saw, v, d, e);
    total += 4;
    if (saw !== 1'b0) begin bad++; $display("FAIL illegal_mem_req got=%b exp=0", saw); end
    if (v !== 1'b1) begin bad++; $display("FAIL illegal_valid got=%b exp=1", v); end
    if (e !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", e); end
    if (d !== 32'h0) begin bad++; $display("FAIL illegal_data got=%h exp=0", d); end
    // Misaligned word and halfword.
    run_load(32'h301, 2'b10, 1'b0, 32'hCAFEF00D, saw, v, d, e);
    total += 4;
    if (v !== 1'b1) begin bad++; $display("FAIL mislw_valid got=%b exp=1", v); end
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    if (saw !== 1'b0) begin bad++; $display("FAIL mislw_mem_req got=%b exp=0", saw); end
    if (e !== 1'b1) begin bad++; $display("FAIL mislw_err got=%b exp=1", e); end
    if (d !== 32'h0) begin bad++; $display("FAIL mislw_data got=%h exp=0", d); end
`else
    if (saw !== 1'b1) begin bad++; $display("FAIL mislw_mem_req got=%b exp=1", saw); end
    if (e !== 1'b0) begin bad++; $display("FAIL mislw_err got=%b exp=0", e); end
    if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL mislw_data got=%h exp=cafef00d", d); end
`endif
    run_load(32'h203, 2'b01, 1'b0, 32'h12347FFE, saw, v, d, e);
    total += 2;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    if (e !== 1'b1) begin bad++; $display("FAIL mislh_err got=%b exp=1", e); end
    if (d !== 32'h0) begin bad++; $display("FAIL mislh_data got=%h exp=0", d); end
`else
    if (e !== 1'b0) begin bad++; $display("FAIL mislh_err got=%b exp=0", e); end
    if (d !== 32'h00007FFE) begin bad++; $display("FAIL mislh_data got=%h exp=00007ffe", d); end
`endif
  endtask

  task automatic test_timeout();
    // No ack: error response exactly 4 cycles after mem_req rises.
    req_valid = 1'b1; req_addr = 32'h500; req_size = 2'b10; req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (mem_req !== 1'b1 || rsp_valid !== 1'b0) begin
        bad++; $display("FAIL to_wait%0d got mem_req=%b rsp_valid=%b exp 1/0", i, mem_req, rsp_valid);
      end
    end
    tick();
    total += 3;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL to_valid got=%b exp=1", rsp_valid); end
    if (rsp_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", rsp_err); end
    if (rsp_data !== 32'h0) begin bad++; $display("FAIL to_data got=%h exp=0", rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    // Ack in the expiry cycle wins.
    req_valid = 1'b1; req_addr = 32'h504;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h01020304;
    tick();
    mem_ack = 1'b0;
    total += 2;
    if (rsp_err !== 1'b0) begin bad++; $display("FAIL to_ack_err got=%b exp=0", rsp_err); end
    if (rsp_data !== 32'h01020304) begin bad++; $display("FAIL to_ack_data got=%h exp=01020304", rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_hold();
    req_valid = 1'b1; req_addr = 32'h600; req_size = 2'b00; req_unsigned = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h9C000000;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000009C || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d got valid=%b data=%h ready=%b exp 1/0000009c/0", i, rsp_valid,
                 rsp_data, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h704; req_size = 2'b10; req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0 || rsp_valid !== 1'b0 ||
        rsp_data !== 32'h0 || rsp_err !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL midreset got rdy=%b mreq=%b maddr=%h rv=%b rd=%h re=%b st=%b exp idle", req_ready,
               mem_req, mem_addr, rsp_valid, rsp_data, rsp_err, stall);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL stray_ack got rdy=%b rv=%b mreq=%b exp 1/0/0", req_ready, rsp_valid, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_addr = 32'h800; req_size = 2'b10; req_unsigned = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA; rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_c1 got=%b exp=0", rsp_valid); end
    tick();
    total += 2;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_lat2 got=%b exp=1", rsp_valid); end
    if (rsp_data !== 32'h55AA55AA) begin bad++; $display("FAIL b2b_data got=%h exp=55aa55aa", rsp_data); end
    tick();
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", req_ready); end
    tick();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b exp=1", mem_req); end
    tick();
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_rsp got=%b exp=1", rsp_valid); end
    req_valid = 1'b0; mem_ack = 1'b0;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_lb();
    test_extend();
    test_errors();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
